// File: rtl/lcd_cmd_issuer.sv
// Host-side initiator for the LCD_CTRL command interface: buffers upstream opcodes,
// issues them one at a time against the controller's busy/done handshake, and watches for hangs.
module lcd_cmd_issuer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       in_cmd,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       cmd,
    output logic             cmd_valid,
    input  logic             busy,
    input  logic             done,
    output logic [CNT_W-1:0] issued_cnt,
    output logic             finished,
    output logic             timeout,
    output logic             illegal,
    output logic [2:0]       dbg_state_o
);

    // Handshakes: upstream push on in_valid & in_ready at a rising edge; the controller
    // gets a one-cycle cmd_valid strobe only while busy is low, then we wait busy high -> low.

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WDW-1:0]   WD_ONE  = WDW'(1);
    localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_BUSYW  = 3'd2,
        S_DRAIN  = 3'd3,
        S_WDONE  = 3'd4,
        S_FIN    = 3'd5,
        S_TOUT   = 3'd6
    } state_t;

    state_t           state_q;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      wr_ptr_d, rd_ptr_d;
    logic [3:0]       cmd_q;
    logic             cmd_valid_q;
    logic [CNT_W-1:0] issued_cnt_q;
    logic             finished_q, timeout_q, illegal_q, last_wr_q;
    logic [WDW-1:0]   wd_q;

    logic       fifo_empty, fifo_full, push;
    logic [3:0] head;
    logic       head_illegal, wd_expired;

    assign wr_ptr_d     = wr_ptr_q + PTR_ONE;
    assign rd_ptr_d     = rd_ptr_q + PTR_ONE;
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign head_illegal = (head[3:2] == 2'b11);
    assign wd_expired   = (wd_q == WD_LAST);

    assign in_ready = !fifo_full && (state_q != S_FIN) && (state_q != S_TOUT);
    assign push     = in_valid && in_ready;

    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign issued_cnt  = issued_cnt_q;
    assign finished    = finished_q;
    assign timeout     = timeout_q;
    assign illegal     = illegal_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            issued_cnt_q <= '0;
            finished_q   <= 1'b0;
            timeout_q    <= 1'b0;
            illegal_q    <= 1'b0;
            last_wr_q    <= 1'b0;
            wd_q         <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_illegal) begin
                            rd_ptr_q  <= rd_ptr_d;
                            illegal_q <= 1'b1;
                        end else if (!busy) begin
                            rd_ptr_q    <= rd_ptr_d;
                            cmd_q       <= head;
                            cmd_valid_q <= 1'b1;
                            last_wr_q   <= (head == 4'h0);
                            if (issued_cnt_q != '1) begin
                                issued_cnt_q <= issued_cnt_q + CNT_ONE;
                            end
                            state_q <= S_STROBE;
                        end
                    end
                end
                S_STROBE: begin
                    cmd_valid_q <= 1'b0;
                    wd_q        <= '0;
                    state_q     <= S_BUSYW;
                end
                S_BUSYW: begin
                    if (busy) begin
                        wd_q    <= '0;
                        state_q <= S_DRAIN;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_TOUT;
                    end else begin
                        wd_q <= wd_q + WD_ONE;
                    end
                end
                S_DRAIN: begin
                    if (!busy) begin
                        wd_q    <= '0;
                        state_q <= last_wr_q ? S_WDONE : S_IDLE;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_TOUT;
                    end else begin
                        wd_q <= wd_q + WD_ONE;
                    end
                end
                S_WDONE: begin
                    if (done) begin
                        finished_q <= 1'b1;
                        state_q    <= S_FIN;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_TOUT;
                    end else begin
                        wd_q <= wd_q + WD_ONE;
                    end
                end
                S_FIN: begin
                    cmd_valid_q <= 1'b0;
                end
                S_TOUT: begin
                    cmd_valid_q <= 1'b0;
                    timeout_q   <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed bench for lcd_cmd_issuer: a small busy responder plus linear scenario steps.
`timescale 1ns/1ps
module tb_lcd_cmd_issuer;

    logic       clk;
    logic       reset;
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic [7:0] issued_cnt;
    logic       finished;
    logic       timeout;
    logic       illegal;
    logic [2:0] dbg_state;

    logic       auto_busy;
    logic       busy_man;
    logic       busy_auto;
    int         busy_cnt;

    int         n_cmp;
    int         n_err;
    int         got_base;
    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];

    assign busy = auto_busy ? busy_auto : busy_man;

    lcd_cmd_issuer #(
        .FIFO_DEPTH    (16),
        .TIMEOUT_CYCLES(1000),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_cmd     (in_cmd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt),
        .finished   (finished),
        .timeout    (timeout),
        .illegal    (illegal),
        .dbg_state_o(dbg_state)
    );

    // Clock / global guard
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_guard observed=hang expected=finish");
        $fatal(1, "bench did not finish");
    end

    // Controller model: busy high for 3 cycles after each strobe; strobe recorder.
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt  = 0;
            busy_auto = 1'b0;
        end else begin
            if (cmd_valid) begin
                got_q.push_back(cmd);
                busy_cnt = 3;
            end
            if (busy_cnt > 0) begin
                busy_auto = 1'b1;
                busy_cnt  = busy_cnt - 1;
            end else begin
                busy_auto = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_cmd    = 4'h0;
        done      = 1'b0;
        auto_busy = 1'b0;
        busy_man  = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        got_base = got_q.size();
        tick();
    endtask

    task automatic push(input logic [3:0] op, output logic acc);
        in_cmd   = op;
        in_valid = 1'b1;
        acc      = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] op);
        logic acc;
        push(op, acc);
        if (op[3:2] != 2'b11) exp_q.push_back(op);
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while ((got_q.size() - got_base) < n && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(tag, 32'(got_q.size() - got_base), 32'(n));
    endtask

    // Scoreboard: compare recorded strobes against expected queue.
    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_base + i < got_q.size())
                chk($sformatf("%s_op%0d", tag, i), 32'(got_q[got_base + i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        logic acc;
        int   n_acc;
        n_cmp = 0;
        n_err = 0;
        got_base = 0;

        // Reset state
        do_reset();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_issued", 32'(issued_cnt), 32'd0);
        chk("rst_finished", 32'(finished), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic: 0x1, 0x5, 0x0 then done
        auto_busy = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("basic_done_ignored", 32'(finished), 32'd0);
        push_exp(4'h1);
        push_exp(4'h5);
        push_exp(4'h0);
        wait_strobes("basic_wait", 3, 60);
        tick();
        tick();
        tick();
        chk("basic_not_yet_finished", 32'(finished), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("basic_finished", 32'(finished), 32'd1);
        chk("basic_issued", 32'(issued_cnt), 32'd3);
        chk("basic_in_ready", 32'(in_ready), 32'd0);
        chk("basic_cmd_valid", 32'(cmd_valid), 32'd0);
        check_stream("basic");

        // Initial busy: 0x9 queued behind a long busy
        do_reset();
        busy_man = 1'b1;
        push_exp(4'h9);
        repeat (20) tick();
        chk("initbusy_no_strobe", 32'(got_q.size() - got_base), 32'd0);
        chk("initbusy_cv_low", 32'(cmd_valid), 32'd0);
        busy_man  = 1'b0;
        auto_busy = 1'b1;
        tick();
        chk("initbusy_cv_high", 32'(cmd_valid), 32'd1);
        chk("initbusy_cmd", 32'(cmd), 32'h9);
        tick();
        chk("initbusy_single_cycle", 32'(cmd_valid), 32'd0);
        repeat (8) tick();
        chk("initbusy_issued", 32'(issued_cnt), 32'd1);
        chk("initbusy_finished", 32'(finished), 32'd0);

        // Illegal drop
        do_reset();
        auto_busy = 1'b1;
        push_exp(4'h2);
        push_exp(4'hE);
        push_exp(4'h3);
        wait_strobes("illegal_wait", 2, 60);
        repeat (10) tick();
        check_stream("illegal");
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_issued", 32'(issued_cnt), 32'd2);

        // FIFO full with busy held
        do_reset();
        busy_man = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            push(4'(1 + (i % 11)), acc);
            if (acc) begin
                n_acc++;
                exp_q.push_back(4'(1 + (i % 11)));
            end
        end
        chk("full_accepted", 32'(n_acc), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_no_strobe", 32'(got_q.size() - got_base), 32'd0);
        auto_busy = 1'b1;
        wait_strobes("full_wait", 16, 200);
        repeat (8) tick();
        check_stream("full");
        chk("full_issued", 32'(issued_cnt), 32'd16);
        chk("full_in_ready_after", 32'(in_ready), 32'd1);

        // Timeout: busy never rises
        do_reset();
        push(4'h4, acc);
        tick();
        chk("tout_strobe", 32'(cmd_valid), 32'd1);
        tick();
        repeat (999) tick();
        chk("tout_not_yet", 32'(timeout), 32'd0);
        tick();
        chk("tout_flag", 32'(timeout), 32'd1);
        chk("tout_cv", 32'(cmd_valid), 32'd0);
        chk("tout_in_ready", 32'(in_ready), 32'd0);
        repeat (5) tick();
        chk("tout_sticky", 32'(timeout), 32'd1);

        // Async reset during STROBE
        do_reset();
        auto_busy = 1'b1;
        push(4'h6, acc);
        tick();
        chk("arst_strobe", 32'(cmd_valid), 32'd1);
        chk("arst_issued_pre", 32'(issued_cnt), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_cv_cleared", 32'(cmd_valid), 32'd0);
        chk("arst_issued_cleared", 32'(issued_cnt), 32'd0);
        #1;
        reset = 1'b1;
        got_base = got_q.size();
        tick();
        push_exp(4'h7);
        wait_strobes("arst_wait", 1, 20);
        repeat (6) tick();
        check_stream("arst");
        chk("arst_issued_post", 32'(issued_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_issuer.md
Name: lcd_cmd_issuer

Overview:
Synthesizable host-side initiator for the LCD_CTRL command interface. It is the counterpart of the controller's cmd/cmd_valid/busy/done handshake. Upstream logic loads an opcode stream into an internal FIFO. The block issues one opcode at a time only while the controller is idle, waits for the busy cycle to finish, then stops after the write opcode (0x0) once done is seen. A watchdog flags a hung controller.

Parameters:
FIFO_DEPTH, 16, command FIFO entries (power of 2, minimum 2)
TIMEOUT_CYCLES, 1000, maximum cycles spent in any wait state before timeout
CNT_W, 8, width of issued-command counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
in_cmd  input  4  opcode from upstream
in_valid  input  1  upstream opcode valid
in_ready  output  1  FIFO can accept; push occurs when in_valid & in_ready at a rising edge
cmd  output  4  opcode to controller
cmd_valid  output  1  one-cycle command strobe to controller
busy  input  1  controller busy
done  input  1  controller completion (level or pulse)
issued_cnt  output  CNT_W  legal commands issued since reset, saturating
finished  output  1  sticky; done received after write opcode
timeout  output  1  sticky; watchdog expired
illegal  output  1  sticky; an opcode 0xC-0xF was dropped

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; state IDLE.
  - cmd=0, cmd_valid=0, issued_cnt=0, finished=0, timeout=0, illegal=0.
  - in_ready=1 combinationally after reset is released.
- Legal opcodes: 0x0 write, 0x1-0x4 shifts, 0x5-0x7 max/min/avg, 0x8-0xB rotate/mirror. Opcodes 0xC-0xF are illegal.
- FIFO:
  - in_ready = !full & state not in {FIN, TOUT}.
  - Push and pop in the same cycle are allowed. When full, in_ready stays 0 in the pop cycle; no push-through.
  - Pointers wrap modulo FIFO_DEPTH.
- States and transitions (registered outputs):
  - IDLE:
    - FIFO empty: stay.
    - Head illegal: pop it, illegal<=1, stay. This happens whatever busy is; one drop per cycle.
    - Head legal and busy==0: pop it, cmd<=head, cmd_valid<=1, issued_cnt++ (saturating), last_wr<=(head==0), go STROBE.
    - Head legal and busy==1: stay.
  - STROBE: cmd_valid is high for exactly this one cycle. On the next edge cmd_valid<=0 and go BUSYW. cmd holds its value until the next issue.
  - BUSYW: wait for busy==1, then go DRAIN.
  - DRAIN: wait for busy==0. Then go WDONE if last_wr, else IDLE.
  - WDONE: done==1 sampled -> finished<=1, go FIN.
  - FIN: terminal until reset. in_ready=0, cmd_valid=0, FIFO contents frozen.
  - TOUT: terminal until reset. timeout=1, in_ready=0, cmd_valid=0.
- Latency: an opcode pushed into an empty FIFO at edge k, with busy=0, drives cmd_valid high in the cycle after edge k+1. Minimum spacing between two strobes is 4 cycles: STROBE, BUSYW with at least 1 cycle of busy, DRAIN, IDLE.
- Watchdog:
  - Counter clears on entry to BUSYW, DRAIN or WDONE and increments each cycle while in those states.
  - When it reaches TIMEOUT_CYCLES, go TOUT.
  - It never runs in IDLE, so waiting for upstream is not a fault.
- done sampled in any state other than WDONE is ignored and has no flag effect.
- busy rising and falling while in IDLE (for example the controller's initial image load) only delays issue.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). The controller side must tolerate a cmd_valid truncated mid-strobe.

Test Plan:
- Basic: push 0x1,0x5,0x0. Model busy high for 3 cycles after each strobe; pulse done 2 cycles after the final busy falls. Expect 3 single-cycle strobes carrying 0x1, 0x5, 0x0 in order, issued_cnt=3, finished=1, in_ready=0.
- Initial busy: hold busy=1 for 20 cycles after reset with 0x9 queued. Expect no cmd_valid until busy falls; the strobe then follows within 2 cycles.
- Illegal drop: push 0x2,0xE,0x3. Expect strobes 0x2 and 0x3 only, illegal=1, issued_cnt=2.
- FIFO full: with FIFO_DEPTH=16 and busy=1 held, push 20 opcodes. Expect exactly 16 accepted, in_ready=0 after the 16th, and no loss or reorder once busy releases.
- Timeout: after one strobe keep busy=0 forever. Expect timeout=1 exactly TIMEOUT_CYCLES cycles after entering BUSYW, cmd_valid=0 and in_ready=0 thereafter.
- Async reset: assert reset during a STROBE cycle. Expect cmd_valid=0 and issued_cnt=0 without waiting for a clock edge; normal issue resumes after release.
